pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised pipeline stall/flush controller; successor to the fixed 6-stage stall generator.
//  - Accepts per-stage stall requests and produces the per-stage stall and bubble vectors.
//  - Sequences multi-cycle flushes with redirect-PC delivery.
//  - Watchdogs stalls that never release.
//  - Sits beside the datapath and drives the enables of every pipeline register.
// PARAMETERS
//  NUM_STAGES     6   pipeline stages, index 0 = PC ... NUM_STAGES-1 = WB
//  FLUSH_STAGE    4   highest stage cleared by a flush (stages 0..FLUSH_STAGE)
//  FLUSH_CYCLES   1   cycles the flush vector is held, >=1
//  STALL_TIMEOUT  1024  consecutive stall cycles before timeout; 0 disables watchdog
//  PC_W           32  redirect PC width
// PORTS
//  clk            in   1           rising-edge clock
//  rst            in   1           reset, synchronous, active-high
//  stall_req      in   NUM_STAGES  bit k: stage k must hold this cycle
//  flush_req      in   1           flush pulse (exception/mispredict)
//  flush_pc       in   PC_W        redirect target, sampled with flush_req
//  stall          out  NUM_STAGES  bit j: hold pipeline register of stage j
//  bubble         out  NUM_STAGES  bit j: load NOP into stage j register
//  flush          out  NUM_STAGES  bit j: clear stage j register
//  new_pc_valid   out  1           one-cycle pulse, load new_pc into PC
//  new_pc         out  PC_W        redirect PC
//  flush_busy     out  1           FSM in FLUSH state
//  stall_timeout  out  1           sticky watchdog flag
//  perf_stall_cyc out  32          stall-cycle counter (optional feature)
//  perf_flush_cnt out  16          completed-flush counter (optional feature)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0; rst mid-flush aborts at once, no new_pc_valid.
//  Stall (combinational, IDLE only):
//  - h = highest set index of stall_req.
//  - stall[j]=1 for j<=h, else 0.
//  - bubble[h+1]=1 if h+1<NUM_STAGES; no bubble when h=NUM_STAGES-1.
//  - stall_req==0 -> stall=0, bubble=0.
//  - Example: N=6, stall_req=6'b001000 -> stall=6'b001111, bubble=6'b010000.
//  FSM states: IDLE, FLUSH.
//  - IDLE, flush_req=1: latch flush_pc, go FLUSH.
//  - Stall outputs that cycle still follow stall_req (flush is registered, 1-cycle latency).
//  - FLUSH, first cycle: new_pc_valid=1, new_pc=latched PC.
//  - FLUSH, every cycle: flush[j]=1 for j<=FLUSH_STAGE, flush_busy=1, stall=0, bubble=0.
//  - Dwell counter runs 0..FLUSH_CYCLES-1, then IDLE.
//  - flush_req during FLUSH is ignored (pipeline already being cleared).
//  - new_pc holds its value after the pulse until the next flush.
//  Watchdog:
//  - stall_cnt increments on each cycle with stall!=0; clears on stall==0 or in FLUSH.
//  - Saturates at STALL_TIMEOUT.
//  - Reaching STALL_TIMEOUT (nonzero) sets stall_timeout; stays set until rst.
//  Widths: h encoder handles any NUM_STAGES>=2; FLUSH_STAGE<NUM_STAGES checked at elaboration.
// CONFIGURATION
//  STALL_PERF_EN defined:
//  - perf_stall_cyc increments on each cycle with stall!=0, wraps at 2^32.
//  - perf_flush_cnt increments on each FLUSH->IDLE exit, wraps at 2^16.
//  - Both clear on rst.
//  STALL_PERF_EN undefined: ports present, tied to 0, no counter flops.
// TESTING
//  1 rst=1 3 cycles, any inputs -> all outputs 0; release, stall_req=0 -> stall=0, bubble=0.
//  2 stall_req=6'b001000 -> stall=6'b001111, bubble=6'b010000; add bit5 -> stall=6'b111111, bubble=0.
//  3 FLUSH_CYCLES=2, flush_req=1 with flush_pc=32'h80000180, stall_req=6'b000100:
//    - Cycle 0: stall=6'b000111.
//    - Cycles 1-2: flush=6'b011111, stall=0.
//    - Cycle 1 only: new_pc_valid=1, new_pc=32'h80000180.
//    - Cycle 3: IDLE.
//  4 flush_req again on cycle 2 of test 3 -> ignored, exactly one new_pc_valid pulse, IDLE at cycle 3.
//  5 STALL_TIMEOUT=8, stall_req=6'b000001 held 8 cycles -> stall_timeout=1 on cycle 8.
//    - Stays 1 after stall_req=0.
//    - Holding only 7 cycles, then a 0-cycle, then 7 more -> stays 0.
//  6 STALL_PERF_EN: 5 stall cycles + 2 flushes -> perf_stall_cyc=5, perf_flush_cnt=2;
//    - Without macro: both read 0.
//    - rst mid-flush -> new_pc_valid never pulses.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: per-stage stall/bubble vectors, flush sequencing with redirect PC,
// and a stall watchdog. Define STALL_PERF_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned NUM_STAGES    = 6,
  parameter int unsigned FLUSH_STAGE   = 4,
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned PC_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  flush_req,
  input  logic [PC_W-1:0]       flush_pc,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] bubble,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  new_pc_valid,
  output logic [PC_W-1:0]       new_pc,
  output logic                  flush_busy,
  output logic                  stall_timeout,
  output logic [31:0]           perf_stall_cyc,
  output logic [15:0]           perf_flush_cnt
);

  localparam int unsigned DwellW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned CntW   = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(FLUSH_CYCLES - 1);
  localparam logic [CntW-1:0]   CntMax    = CntW'(STALL_TIMEOUT);

  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("pipe_hazard_ctrl: NUM_STAGES must be >= 2");
  end
  if (FLUSH_STAGE >= NUM_STAGES) begin : g_bad_flush_stage
    $error("pipe_hazard_ctrl: FLUSH_STAGE must be < NUM_STAGES");
  end
  if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
    $error("pipe_hazard_ctrl: FLUSH_CYCLES must be >= 1");
  end

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e            state_q, state_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [PC_W-1:0]   new_pc_q, new_pc_d;
  logic [CntW-1:0]   stall_cnt_q, stall_cnt_d;
  logic              timeout_q, timeout_d;

  logic [NUM_STAGES-1:0] stall_v, bubble_v, flush_v;
  logic                  acc;

  // Every stage at or below the highest requester holds; the first stage above it takes a NOP.
  always_comb begin
    acc      = 1'b0;
    stall_v  = '0;
    bubble_v = '0;
    flush_v  = '0;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      acc        = acc | stall_req[j];
      stall_v[j] = acc;
    end
    if (state_q != StIdle) stall_v = '0;
    for (int j = 1; j < NUM_STAGES; j++) begin
      bubble_v[j] = stall_v[j-1] & ~stall_v[j];
    end
    for (int unsigned j = 0; j < NUM_STAGES; j++) begin
      flush_v[j] = (state_q == StFlush) && (j <= FLUSH_STAGE);
    end
  end

  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    new_pc_d = new_pc_q;
    unique case (state_q)
      StIdle: begin
        if (flush_req) begin
          new_pc_d = flush_pc;
          dwell_d  = '0;
          state_d  = StFlush;
        end
      end
      StFlush: begin
        // A new flush_req here is dropped: the pipeline is already being cleared.
        if (dwell_q == DwellLast) begin
          dwell_d = '0;
          state_d = StIdle;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((STALL_TIMEOUT == 0) || (state_q == StFlush) || (stall_v == '0)) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != CntMax) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    timeout_d = timeout_q | ((STALL_TIMEOUT != 0) && (stall_cnt_d == CntMax));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      dwell_q     <= '0;
      new_pc_q    <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      new_pc_q    <= new_pc_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Reset masks all outputs in the same cycle so a mid-flush reset can never emit a redirect.
  assign stall         = rst ? '0 : stall_v;
  assign bubble        = rst ? '0 : bubble_v;
  assign flush         = rst ? '0 : flush_v;
  assign new_pc_valid  = !rst && (state_q == StFlush) && (dwell_q == '0);
  assign new_pc        = rst ? '0 : new_pc_q;
  assign flush_busy    = !rst && (state_q == StFlush);
  assign stall_timeout = !rst && timeout_q;

`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [15:0] perf_flush_q;
  logic        flush_exit;

  assign flush_exit = (state_q == StFlush) && (state_d == StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_v != '0) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush_exit)    perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign perf_stall_cyc = rst ? '0 : perf_stall_q;
  assign perf_flush_cnt = rst ? '0 : perf_flush_q;
`else
  assign perf_stall_cyc = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, STALL_TIMEOUT=8), checked with immediate asserts.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  stall_req;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall, bubble, flush;
  logic        new_pc_valid, flush_busy, stall_timeout;
  logic [31:0] new_pc, perf_stall_cyc;
  logic [15:0] perf_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef STALL_PERF_EN
  localparam logic [31:0] ExpPerfStall = 32'd5;
  localparam logic [15:0] ExpPerfFlush = 16'd2;
`else
  localparam logic [31:0] ExpPerfStall = 32'd0;
  localparam logic [15:0] ExpPerfFlush = 16'd0;
`endif

  pipe_hazard_ctrl #(
    .NUM_STAGES   (6),
    .FLUSH_STAGE  (4),
    .FLUSH_CYCLES (2),
    .STALL_TIMEOUT(8),
    .PC_W         (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_req     (stall_req),
    .flush_req     (flush_req),
    .flush_pc      (flush_pc),
    .stall         (stall),
    .bubble        (bubble),
    .flush         (flush),
    .new_pc_valid  (new_pc_valid),
    .new_pc        (new_pc),
    .flush_busy    (flush_busy),
    .stall_timeout (stall_timeout),
    .perf_stall_cyc(perf_stall_cyc),
    .perf_flush_cnt(perf_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic reset_dut();
    step();
    rst = 1'b1; stall_req = '0; flush_req = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Test 1: reset with hostile inputs
    rst = 1'b1; stall_req = 6'b111111; flush_req = 1'b1; flush_pc = 32'hFFFF_FFFF;
    repeat (3) step();
    #1;
    chk("rst_stall", stall, 6'b0);
    chk("rst_bubble", bubble, 6'b0);
    chk("rst_flush", flush, 6'b0);
    chk("rst_npv", new_pc_valid, 1'b0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_busy", flush_busy, 1'b0);
    chk("rst_timeout", stall_timeout, 1'b0);
    chk("rst_perf_stall", perf_stall_cyc, 32'h0);
    chk("rst_perf_flush", perf_flush_cnt, 16'h0);
    rst = 1'b0; stall_req = '0; flush_req = 1'b0;
    #1;
    chk("idle_stall", stall, 6'b0);
    chk("idle_bubble", bubble, 6'b0);

    // Test 2: stall/bubble encoding
    step(); stall_req = 6'b001000; #1;
    chk("s3_stall", stall, 6'b001111);
    chk("s3_bubble", bubble, 6'b010000);
    step(); stall_req = 6'b101000; #1;
    chk("s5_stall", stall, 6'b111111);
    chk("s5_bubble", bubble, 6'b000000);
    step(); stall_req = 6'b000001; #1;
    chk("s0_stall", stall, 6'b000001);
    chk("s0_bubble", bubble, 6'b000010);
    step(); stall_req = '0; #1;
    chk("s_none", stall, 6'b0);

    // Test 3: two-cycle flush
    step(); stall_req = 6'b000100; flush_req = 1'b1; flush_pc = 32'h8000_0180; #1;
    chk("f0_stall", stall, 6'b000111);
    chk("f0_bubble", bubble, 6'b001000);
    chk("f0_flush", flush, 6'b0);
    chk("f0_npv", new_pc_valid, 1'b0);
    step(); flush_req = 1'b0; #1;
    chk("f1_flush", flush, 6'b011111);
    chk("f1_stall", stall, 6'b0);
    chk("f1_bubble", bubble, 6'b0);
    chk("f1_npv", new_pc_valid, 1'b1);
    chk("f1_new_pc", new_pc, 32'h8000_0180);
    chk("f1_busy", flush_busy, 1'b1);
    step(); #1;
    chk("f2_flush", flush, 6'b011111);
    chk("f2_stall", stall, 6'b0);
    chk("f2_npv", new_pc_valid, 1'b0);
    chk("f2_busy", flush_busy, 1'b1);
    step(); stall_req = '0; #1;
    chk("f3_busy", flush_busy, 1'b0);
    chk("f3_flush", flush, 6'b0);
    chk("f3_new_pc", new_pc, 32'h8000_0180);

    // Test 4: flush_req during FLUSH is ignored
    step(); flush_req = 1'b1; flush_pc = 32'h0000_1000; #1;
    step(); flush_req = 1'b0; #1;
    chk("g1_npv", new_pc_valid, 1'b1);
    chk("g1_new_pc", new_pc, 32'h0000_1000);
    step(); flush_req = 1'b1; flush_pc = 32'hDEAD_0000; #1;
    chk("g2_npv", new_pc_valid, 1'b0);
    step(); flush_req = 1'b0; #1;
    chk("g3_busy", flush_busy, 1'b0);
    chk("g3_npv", new_pc_valid, 1'b0);
    step(); #1;
    chk("g4_npv", new_pc_valid, 1'b0);
    chk("g4_busy", flush_busy, 1'b0);
    chk("g4_new_pc", new_pc, 32'h0000_1000);

    // Test 5: watchdog
    step(); stall_req = 6'b000001;
    repeat (7) step();
    #1;
    chk("wd_c7", stall_timeout, 1'b0);
    step(); stall_req = '0; #1;
    chk("wd_c8", stall_timeout, 1'b1);
    step(); #1;
    chk("wd_sticky", stall_timeout, 1'b1);
    reset_dut(); #1;
    chk("wd_rst", stall_timeout, 1'b0);
    stall_req = 6'b000001;
    repeat (6) step();
    step(); stall_req = '0;
    step(); stall_req = 6'b000001;
    repeat (6) step();
    step(); stall_req = '0; #1;
    chk("wd_7_0_7", stall_timeout, 1'b0);
    step(); #1;
    chk("wd_7_0_7b", stall_timeout, 1'b0);

    // Test 6: performance counters and reset mid-flush
    reset_dut();
    stall_req = 6'b000010;
    repeat (4) step();
    step(); stall_req = '0;
    repeat (2) begin
      step(); flush_req = 1'b1; flush_pc = 32'h0000_2000;
      step(); flush_req = 1'b0;
      step();
      step();
    end
    #1;
    chk("perf_stall", perf_stall_cyc, ExpPerfStall);
    chk("perf_flush", perf_flush_cnt, ExpPerfFlush);
    step(); flush_req = 1'b1; flush_pc = 32'h0000_1234; #1;
    step(); flush_req = 1'b0; rst = 1'b1; #1;
    chk("mr_npv", new_pc_valid, 1'b0);
    chk("mr_busy", flush_busy, 1'b0);
    chk("mr_flush", flush, 6'b0);
    step(); rst = 1'b0; #1;
    chk("mr_npv2", new_pc_valid, 1'b0);
    chk("mr_new_pc", new_pc, 32'h0);
    chk("mr_busy2", flush_busy, 1'b0);
    chk("mr_perf_stall", perf_stall_cyc, 32'h0);
    chk("mr_perf_flush", perf_flush_cnt, 16'h0);
    step(); #1;
    chk("mr_npv3", new_pc_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
